rgb_fade_sequencer: RTL

//   Drives the board RGB LED from a fade-sequencing controller on the PLL global clock.

---
 rtl/rgb_fade_sequencer_if.sv | 8 +
 rtl/rgb_fade_sequencer.sv | 76 +++++++
 2 files changed

// File: rtl/rgb_fade_sequencer_if.sv
// rgb_fade_sequencer_if: valid/ready colour-command channel
interface rgb_fade_sequencer_if #(parameter int PWM_BITS = 8);
  logic cmd_valid;
  logic cmd_ready;
  logic [3*PWM_BITS-1:0] cmd_rgb;
  modport master(output cmd_valid, cmd_rgb, input cmd_ready);
  modport slave(input cmd_valid, cmd_rgb, output cmd_ready);
endinterface

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: ramps RGB PWM duties toward a commanded colour, holds, then idles
module rgb_fade_sequencer #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 16,
  parameter int HOLD_TICKS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  rgb_fade_sequencer_if.slave cmd,
  output logic busy,
  output logic LED_RED,
  output logic LED_GREEN,
  output logic LED_BLUE
);
  localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;
  state_t state, state_n;
  logic [2:0][PWM_BITS-1:0] duty, duty_n, target, target_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_DIV-1:0] prescaler, prescaler_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic tick, accept;
  assign cmd.cmd_ready = (state == IDLE) & enable & ~rst;
  assign busy = state != IDLE;
  assign tick = enable & (&prescaler);
  assign accept = cmd.cmd_valid & cmd.cmd_ready;
  // next-state: accept into FADE, step duties per tick, count HOLD ticks back to IDLE
  always_comb begin
    state_n = state;
    duty_n = duty;
    target_n = target;
    hold_cnt_n = hold_cnt;
    prescaler_n = (enable && state != IDLE) ? prescaler + 1'b1 : prescaler;
    if (state == IDLE && accept) begin
      state_n = FADE;
      target_n = cmd.cmd_rgb;
      prescaler_n = '0;
    end else if (state == FADE && tick) begin
      if (duty == target) begin
        state_n = HOLD;
        hold_cnt_n = '0;
      end else begin
        for (int i = 0; i < 3; i++)
          duty_n[i] = duty[i] < target[i] ? duty[i] + 1'b1 :
                      duty[i] > target[i] ? duty[i] - 1'b1 : duty[i];
      end
    end else if (state == HOLD && tick) begin
      state_n = hold_cnt == HW'(HOLD_TICKS - 1) ? IDLE : HOLD;
      hold_cnt_n = hold_cnt + 1'b1;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty <= '0;
      target <= '0;
      prescaler <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      duty <= duty_n;
      target <= target_n;
      prescaler <= prescaler_n;
      hold_cnt <= hold_cnt_n;
    end
  end
  // free-running PWM counter and registered LED compare, gated by enable
  always_ff @(posedge clk) begin
    pwm_cnt <= rst ? '0 : pwm_cnt + 1'b1;
    LED_RED <= ~rst & enable & (pwm_cnt < duty[2]);
    LED_GREEN <= ~rst & enable & (pwm_cnt < duty[1]);
    LED_BLUE <= ~rst & enable & (pwm_cnt < duty[0]);
  end
endmodule
